// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 UART PHY.
//   - 2-bit RX/TX FSM state encodings
//   - 8N1 frame constants and the default line rate
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int FRAME_BITS   = 10;     // start + 8 data + stop
  localparam int DEFAULT_BAUD = 115200;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_phy_baud_timer.sv
// baud_timer: loadable bit-period down-counter shared by the RX and TX paths.
// Ports:
//   clk50MHz  system clock
//   rst       synchronous active-high reset (counter clears)
//   load      load CLKS_PER_BIT-1, or CLKS_PER_BIT/2-1 when half=1
//   half      select the half-period load (RX start-bit centring)
//   en        count enable; tick is only produced while enabled
//   tick      1-cycle pulse in the cycle the counter sits at 0; it reloads
//             the full period on that same edge
module baud_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk50MHz,
  input  logic rst,
  input  logic load,
  input  logic half,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_M1 = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_M1 = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk50MHz) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= half ? HALF_M1 : FULL_M1;
    else if (en)
      cnt <= (cnt == '0) ? FULL_M1 : cnt - 1'b1;
  end

endmodule

// File: rtl/uart_phy.sv
// uart_phy: 8N1 UART transceiver on the 50 MHz system clock.
// Ports:
//   clk50MHz        system clock
//   rst             synchronous active-high reset
//   rx              asynchronous serial input (idle high)
//   tx              serial output (idle high)
//   data_out        last received byte, held until the next good byte
//   data_out_valid  1-cycle pulse when data_out updates
//   data_in         byte to transmit, captured on acceptance
//   data_in_valid   transmit request, accepted when !busy
//   busy            transmitter occupied (10 bit periods per frame)
//   frame_err       1-cycle pulse on a bad stop bit (UART_FRAMING_CHECK_EN only)
// Build option: define UART_FRAMING_CHECK_EN to drop bytes with a bad stop
// bit and report them on frame_err; otherwise every byte is delivered.
module uart_phy import uart_pkg::*; #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       busy
`ifdef UART_FRAMING_CHECK_EN
  ,
  output logic       frame_err
`endif
);

  localparam int RXT = 0;
  localparam int TXT = 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // one bit-period timer per direction
  logic [1:0] bt_load, bt_half, bt_en, bt_tick;

  for (genvar i = 0; i < 2; i++) begin : g_bt
    baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bt (
      .clk50MHz (clk50MHz),
      .rst      (rst),
      .load     (bt_load[i]),
      .half     (bt_half[i]),
      .en       (bt_en[i]),
      .tick     (bt_tick[i])
    );
  end

  // ---------------- RX ----------------
  // 2-flop synchronizer plus one history flop for edge detect; all reset
  // to the idle level so reset release never looks like a start edge.
  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_s, rx_fall, rx_arm;

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;

  rx_state_t  rx_st;
  logic [2:0] rx_idx;
  logic [7:0] rx_sh;

`ifdef UART_FRAMING_CHECK_EN
  // after a framing error, stay disarmed until the line is seen high again
  logic rx_hold;
  assign rx_arm = rx_fall && !rx_hold;
`else
  assign rx_arm = rx_fall;
`endif

  assign bt_load[RXT] = (rx_st == RX_IDLE) && rx_arm;
  assign bt_half[RXT] = 1'b1;   // first wait lands mid start bit
  assign bt_en[RXT]   = (rx_st != RX_IDLE);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      rx_st          <= RX_IDLE;
      rx_idx         <= '0;
      rx_sh          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
      frame_err      <= 1'b0;
      rx_hold        <= 1'b0;
`endif
    end else begin
      data_out_valid <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
      frame_err      <= 1'b0;
      if (rx_st == RX_IDLE && rx_s) rx_hold <= 1'b0;
`endif
      case (rx_st)
        RX_IDLE:
          if (rx_arm) rx_st <= RX_START;
        RX_START:
          if (bt_tick[RXT]) begin
            if (rx_s) rx_st <= RX_IDLE;       // too short: glitch
            else begin
              rx_st  <= RX_DATA;
              rx_idx <= '0;
            end
          end
        RX_DATA:
          if (bt_tick[RXT]) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};     // LSB arrives first
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == LAST_BIT) rx_st <= RX_STOP;
          end
        RX_STOP:
          if (bt_tick[RXT]) begin
            rx_st <= RX_IDLE;
`ifdef UART_FRAMING_CHECK_EN
            if (!rx_s) begin
              frame_err <= 1'b1;
              rx_hold   <= 1'b1;
            end else begin
              data_out       <= rx_sh;
              data_out_valid <= 1'b1;
            end
`else
            data_out       <= rx_sh;
            data_out_valid <= 1'b1;
`endif
          end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX ----------------
  // busy mirrors tx_st != TX_IDLE but is kept as its own register so the
  // output is flop-driven.
  tx_state_t  tx_st;
  logic [2:0] tx_idx;
  logic [7:0] tx_sh;
  logic       tx_go;

  assign tx_go        = data_in_valid && !busy;
  assign bt_load[TXT] = tx_go;
  assign bt_half[TXT] = 1'b0;
  assign bt_en[TXT]   = (tx_st != TX_IDLE);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx     <= 1'b1;
      busy   <= 1'b0;
    end else begin
      case (tx_st)
        TX_IDLE:
          if (tx_go) begin
            tx_st  <= TX_START;
            tx_sh  <= data_in;
            tx_idx <= '0;
            tx     <= 1'b0;
            busy   <= 1'b1;
          end
        TX_START:
          if (bt_tick[TXT]) begin
            tx_st <= TX_DATA;
            tx    <= tx_sh[0];
            tx_sh <= {1'b0, tx_sh[7:1]};
          end
        TX_DATA:
          if (bt_tick[TXT]) begin
            if (tx_idx == LAST_BIT) begin
              tx_st <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              tx     <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_idx <= tx_idx + 3'd1;
            end
          end
        TX_STOP:
          if (bt_tick[TXT]) begin
            tx_st <= TX_IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule
